// File: rtl/seq_detect_arbiter_pkg.sv
// Shared types and constants for the time-shared sequence detector.
package seq_detect_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StReport
  } state_e;

  // Width of the requester ID carried with each job.
  localparam int unsigned IdW = 1;

endpackage

// File: rtl/seq_match_core.sv
// Overlapping serial pattern matcher: PAT_W-bit history plus saturating match counter.
module seq_match_core
  import seq_detect_arbiter_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             armed,
  output logic [CNT_W-1:0] count
);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Shift the new bit into history; count a match against the updated history.
  always_comb begin
    hist_d  = hist_q;
    count_d = count_q;
    if (clr) begin
      hist_d  = '0;
      count_d = '0;
    end else if (shift_en) begin
      hist_d = PAT_W'({hist_q, bit_in});
      // armed gates out matches against the cleared (all-zero) history of a fresh word
      if (armed && (hist_d == pattern) && (count_q != {CNT_W{1'b1}})) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // History and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      count_q <= '0;
    end else begin
      hist_q  <= hist_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detect_arbiter.sv
// Two-requester round-robin front end sharing one serial sequence detector.
module seq_detect_arbiter
  import seq_detect_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              busy,
  output logic              done_valid,
  output logic [IdW-1:0]    done_id,
  output logic [CNT_W-1:0]  done_cnt
);

  localparam int unsigned BitCntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  if (PAT_W > DATA_W || PAT_W < 1) begin : g_bad_pat_w
    $error("seq_detect_arbiter: PAT_W must be in 1..DATA_W");
  end

  state_e               state_q, state_d;
  logic   [IdW-1:0]     last_q, last_d;
  logic   [IdW-1:0]     id_q, id_d;
  logic   [DATA_W-1:0]  data_q, data_d;
  logic   [PAT_W-1:0]   pat_q, pat_d;
  logic   [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic   [IdW-1:0]     done_id_q, done_id_d;
  logic   [CNT_W-1:0]   done_cnt_q, done_cnt_d;
  logic                 grant0, grant1;
  logic                 core_clr, shift_en, armed;
  logic   [CNT_W-1:0]   core_count;

  // Round-robin pick: a lone requester wins; on a tie, the one not granted last.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || (last_q == IdW'(1)));
    grant1 = req1_valid && (!req0_valid || (last_q == IdW'(0)));
  end

  // FSM next state, handshake and datapath control.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    data_d     = data_q;
    pat_d      = pat_q;
    bit_cnt_d  = bit_cnt_q;
    done_id_d  = done_id_q;
    done_cnt_d = done_cnt_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    core_clr   = 1'b0;
    shift_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant0 || grant1) begin
          req0_ready = grant0;
          req1_ready = grant1;
          id_d       = grant1 ? IdW'(1) : IdW'(0);
          last_d     = id_d;
          data_d     = grant1 ? req1_data : req0_data;
          pat_d      = cfg_pattern;
          bit_cnt_d  = '0;
          core_clr   = 1'b1;
          state_d    = StShift;
        end
      end
      StShift: begin
        shift_en  = 1'b1;
        data_d    = data_q << 1;
        bit_cnt_d = bit_cnt_q + BitCntW'(1);
        if (bit_cnt_q == BitCntW'(DATA_W - 1)) begin
          state_d = StReport;
        end
      end
      StReport: begin
        done_id_d  = id_q;
        done_cnt_d = core_count;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_q     <= IdW'(1);
      id_q       <= '0;
      data_q     <= '0;
      pat_q      <= '0;
      bit_cnt_q  <= '0;
      done_id_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      data_q     <= data_d;
      pat_q      <= pat_d;
      bit_cnt_q  <= bit_cnt_d;
      done_id_q  <= done_id_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  // bit_cnt_q counts bits already shifted, so the current bit is number bit_cnt_q+1.
  assign armed = (bit_cnt_q >= BitCntW'(PAT_W - 1));

  seq_match_core #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (core_clr),
    .shift_en (shift_en),
    .bit_in   (data_q[DATA_W-1]),
    .pattern  (pat_q),
    .armed    (armed),
    .count    (core_count)
  );

  // Results come live from the job during REPORT and are held afterwards.
  always_comb begin
    busy       = (state_q != StIdle);
    done_valid = (state_q == StReport);
    done_id    = done_valid ? id_q : done_id_q;
    done_cnt   = done_valid ? core_count : done_cnt_q;
  end

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Scoreboard bench for seq_detect_arbiter: default instance plus a CNT_W=2 saturation instance.
module tb_seq_detect_arbiter;

  localparam int unsigned DataW   = 8;
  localparam int unsigned PatW    = 4;
  localparam int unsigned CntW    = 5;
  localparam int unsigned CntWSat = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PatW-1:0]  cfg_pattern = '0;
  logic             req0_valid = 1'b0;
  logic [DataW-1:0] req0_data = '0;
  logic             req1_valid = 1'b0;
  logic [DataW-1:0] req1_data = '0;

  logic               req0_ready, req1_ready, busy, done_valid;
  logic [0:0]         done_id;
  logic [CntW-1:0]    done_cnt;
  logic               req0_ready_s, req1_ready_s, busy_s, done_valid_s;
  logic [0:0]         done_id_s;
  logic [CntWSat-1:0] done_cnt_s;

  always #5 clk = ~clk;

  seq_detect_arbiter #(
    .DATA_W (DataW),
    .PAT_W  (PatW),
    .CNT_W  (CntW)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_pattern (cfg_pattern),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .busy        (busy),
    .done_valid  (done_valid),
    .done_id     (done_id),
    .done_cnt    (done_cnt)
  );

  seq_detect_arbiter #(
    .DATA_W (DataW),
    .PAT_W  (PatW),
    .CNT_W  (CntWSat)
  ) u_dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_pattern (cfg_pattern),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready_s),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready_s),
    .busy        (busy_s),
    .done_valid  (done_valid_s),
    .done_id     (done_id_s),
    .done_cnt    (done_cnt_s)
  );

  typedef struct {
    int unsigned id;
    int unsigned cnt;
    int unsigned cnt_sat;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned m_left = 0;
  bit          m_last = 1'b1;
  bit          g0, g1;
  int unsigned last_id = 0;
  int unsigned last_cnt = 0;
  int unsigned last_cnt_s = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: MSB-first overlapping matcher, no match before PAT_W bits, saturating.
  function automatic int unsigned model_cnt(input logic [DataW-1:0] w,
                                            input logic [PatW-1:0] p,
                                            input int unsigned cw);
    logic [PatW-1:0] h;
    int unsigned     c;
    int unsigned     cmax;
    h    = '0;
    c    = 0;
    cmax = (1 << cw) - 1;
    for (int i = 0; i < int'(DataW); i++) begin
      h = {h[PatW-2:0], w[DataW-1-i]};
      if ((i + 1 >= int'(PatW)) && (h == p) && (c < cmax)) c++;
    end
    return c;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: model the arbiter/FSM timing, push expectations at grant, pop at done.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", busy, 0);
      check("rst_done_valid", done_valid, 0);
      check("rst_done_id", done_id, 0);
      check("rst_done_cnt", done_cnt, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      sb_q.delete();
      m_left     = 0;
      m_last     = 1'b1;
      last_id    = 0;
      last_cnt   = 0;
      last_cnt_s = 0;
    end else begin
      if (done_valid) begin
        if (sb_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("done_id", done_id, mon_e.id);
          check("done_cnt", done_cnt, mon_e.cnt);
          check("done_cyc", cyc, mon_e.cyc);
          check("sat_done_valid", done_valid_s, 1);
          check("sat_done_id", done_id_s, mon_e.id);
          check("sat_done_cnt", done_cnt_s, mon_e.cnt_sat);
          last_id    = mon_e.id;
          last_cnt   = mon_e.cnt;
          last_cnt_s = mon_e.cnt_sat;
        end
      end else begin
        check("hold_done_id", done_id, last_id);
        check("hold_done_cnt", done_cnt, last_cnt);
        check("hold_sat_cnt", done_cnt_s, last_cnt_s);
        if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
          check("done_missing", cyc, sb_q[0].cyc);
          void'(sb_q.pop_front());
        end
      end
      if (m_left > 0) begin
        check("busy_job", busy, 1);
        check("busy_job_sat", busy_s, 1);
        check("ready0_job", req0_ready, 0);
        check("ready1_job", req1_ready, 0);
        m_left--;
      end else begin
        g0 = req0_valid && (!req1_valid || m_last);
        g1 = req1_valid && (!req0_valid || !m_last);
        check("busy_idle", busy, 0);
        check("ready0", req0_ready, g0);
        check("ready1", req1_ready, g1);
        check("ready0_sat", req0_ready_s, g0);
        check("ready1_sat", req1_ready_s, g1);
        if (g0 || g1) begin
          sb_q.push_back('{id: g1 ? 1 : 0,
                           cnt: model_cnt(g1 ? req1_data : req0_data, cfg_pattern, CntW),
                           cnt_sat: model_cnt(g1 ? req1_data : req0_data, cfg_pattern, CntWSat),
                           cyc: cyc + DataW + 1});
          m_last = g1;
          m_left = DataW + 1;
        end
      end
    end
  end

  // Present one word on a requester and hold it until that requester's ready.
  task automatic send(input int unsigned id, input logic [DataW-1:0] d);
    bit got;
    got = 1'b0;
    if (id == 0) begin
      req0_valid = 1'b1;
      req0_data  = d;
    end else begin
      req1_valid = 1'b1;
      req1_data  = d;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
    end
    check("grant_wait", got, 1);
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_wait", ok, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cfg_pattern = 4'b1101;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both requesters valid from the first cycle: expect 0,1,0,1 every 10 cycles.
    fork
      begin
        send(0, 8'b1101_1010);
        send(0, 8'h3C);
      end
      begin
        send(1, 8'h5B);
        send(1, 8'hA6);
      end
    join
    wait_idle();

    // Basic overlap: two matches.
    send(0, 8'b1101_1010);
    wait_idle();

    // All ones: five matches, saturating at 3 in the narrow instance.
    cfg_pattern = 4'b1111;
    send(1, 8'hFF);
    wait_idle();

    // Previous word ends in zeros; next must not match before 4 bits nor reuse history.
    cfg_pattern = 4'b0000;
    send(0, 8'hF0);
    send(1, 8'h0F);
    wait_idle();

    // Mid-job pattern change is ignored.
    cfg_pattern = 4'b1101;
    send(0, 8'b1101_1010);
    repeat (2) @(posedge clk);
    #1;
    cfg_pattern = 4'b0000;
    wait_idle();

    // Reset during the 4th SHIFT cycle aborts the job.
    cfg_pattern = 4'b1101;
    send(0, 8'b1101_1010);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    send(1, 8'hDD);
    fork
      send(0, 8'h6D);
      send(1, 8'hB6);
    join
    wait_idle();

    // Random mix of patterns, words and requesters.
    for (int k = 0; k < 8; k++) begin
      cfg_pattern = PatW'($urandom);
      if (k % 3 == 0) begin
        fork
          send(0, DataW'($urandom));
          send(1, DataW'($urandom));
        join
      end else begin
        send($urandom_range(0, 1), DataW'($urandom));
      end
    end
    wait_idle();

    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_arbiter.md
# seq_detect_arbiter

Shares one serial pattern-matching engine between two parallel-word requesters. Each accepted word is shifted MSB-first through a programmable overlapping sequence detector, and matches are counted. One result per word is reported on a done strobe, tagged with the requester ID. The block sits between the upstream word sources and the status/statistics logic, and replaces per-source detectors with a single time-shared one.

## Interface
- DATA_W, 8: word width, bits serialized per job.
- PAT_W, 4: pattern length; elaboration error if PAT_W > DATA_W or PAT_W < 1.
- CNT_W, 5: match counter width; the counter saturates.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_pattern  in  PAT_W  pattern to detect; MSB is the first bit expected. Sampled only at job acceptance.
- req0_valid  in  1  requester 0 word valid.
- req0_data  in  DATA_W  requester 0 word.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid, req1_data, req1_ready: same as requester 0, for requester 1.
- busy  out  1  a job is in SHIFT or REPORT.
- done_valid  out  1  one-cycle result strobe.
- done_id  out  1  requester that owns the result.
- done_cnt  out  CNT_W  match count for the word.

## Operation
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - If any valid is high, grant one requester: the only valid one, or, when both are valid, the one not granted last.
  - The round-robin pointer resets to "last = 1", so requester 0 wins the first tie.
  - The granted requester's ready is asserted combinationally in the same cycle; both readys are low in every other state.
  - On handshake, capture the data word into the shift register and latch cfg_pattern. Clear the history register, bit counter and match counter. Record the ID, update the pointer, and go to SHIFT.
- SHIFT, one bit per cycle for DATA_W cycles:
  - Shift data MSB-first into a PAT_W-bit history register.
  - A match occurs when the updated history equals the latched pattern and at least PAT_W bits of the current word have been shifted.
  - Overlapping matches all count.
  - match count increments by 1 and saturates at 2^CNT_W−1.
  - After the DATA_W-th bit, go to REPORT.
- REPORT: done_valid = 1 for exactly one cycle, with done_id and the final done_cnt; then return to IDLE.
- History is cleared per job; matches never span two words.
- Requesters must hold valid and data stable until ready. Dropping valid before grant is a protocol violation and its behaviour is undefined.
- A cfg_pattern change mid-job has no effect on the current job.
- No done-side backpressure: the consumer must accept every strobe.

## Timing
- Reset values: req*_ready = 0, busy = 0, done_valid = 0, done_id = 0, done_cnt = 0. FSM starts in IDLE and the pointer in "last = 1".
- Handshake in cycle T: SHIFT occupies T+1 … T+DATA_W, and done_valid is high in cycle T+DATA_W+1.
- busy is high from T+1 through T+DATA_W+1.
- The next grant is possible in T+DATA_W+2, so peak throughput is one word per DATA_W+2 cycles.
- done_id and done_cnt hold their last value after the strobe until the next REPORT.
- Reset asserted mid-job aborts immediately: no done strobe, counter and ID cleared, pointer returns to its reset value.
- A request arriving during SHIFT or REPORT waits; it is considered at the next IDLE cycle, with the tie-break applied at that moment.

## Structure
- Shared package: state enumeration (IDLE/SHIFT/REPORT) and the requester-ID width constant (1).
- Sub-module seq_match_core (parameters PAT_W, CNT_W):
  - Inputs: clr, shift_en, bit_in, pattern, armed.
  - Output: saturating count.
  - Contains the history register and the match comparator.
- The top level holds the arbiter, FSM, bit counter and data shift register.

## Test plan
- Defaults, pattern 4'b1101, req0 sends 8'b1101_1010 → done_valid at handshake+9, done_id = 0, done_cnt = 2 (overlapping matches at bits 7–4 and 4–1).
- Pattern 4'b1111, req1 sends 8'hFF → done_cnt = 5, done_id = 1. With CNT_W = 2 the same stimulus gives done_cnt = 3 (saturation).
- Both requesters valid continuously from the first cycle after reset → grant order 0,1,0,1. Each done_id matches its job's source, with one job every 10 cycles.
- Pattern 4'b0000, word 8'h0F → done_cnt = 1, which checks that no match fires before 4 bits are shifted and that history is not carried over from the previous job.
- Reset asserted at the 4th SHIFT cycle of a req0 job → no done_valid, all outputs 0. After release, req1 alone is granted first, and a later tie goes to requester 0.
- cfg_pattern changed from 4'b1101 to 4'b0000 during SHIFT with word 8'b1101_1010 → done_cnt = 2 (the latched pattern is used).
